// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x oversampling UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE  = 16;
    localparam int MID_LO      = 7;
    localparam int MID_HI      = 9;
    localparam int LAST_SAMPLE = 15;
    localparam int DATA_BITS   = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every DIV clocks, re-phased by restart.
module uart_baud_tick #(
    parameter int DIV = 26
) (
    input  logic clk,
    input  logic srst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (srst || restart) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = w_wrap && !restart;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, 16x oversampling FSM with 3-sample
// majority vote, and a one-byte holding register with sticky error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 48_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);

    logic       r_sync1;
    logic       r_sync2;
    logic [1:0] r_primed;
    rx_state_t  r_state;
    logic [3:0] r_sample;
    logic [2:0] r_bit_idx;
    logic [1:0] r_votes;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_overrun;
    logic       r_frame_err;

    rx_state_t  w_state_next;
    logic [3:0] w_sample_next;
    logic [2:0] w_bit_idx_next;
    logic [1:0] w_votes_next;
    logic [7:0] w_shift_next;
    logic       w_restart;
    logic       w_deliver;
    logic       w_frame_set;
    logic       w_tick;
    logic       w_rx;
    logic [3:0] w_cnt_inc;
    logic       w_mid;
    logic       w_bit_end;
    logic       w_maj;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk    (clk_48mhz),
        .srst   (reset),
        .restart(w_restart),
        .tick   (w_tick)
    );

    assign w_rx      = r_sync2;
    assign w_cnt_inc = r_sample + 4'd1;
    assign w_mid     = w_tick && (w_cnt_inc == 4'(MID_HI));
    assign w_bit_end = w_tick && (r_sample == 4'(LAST_SAMPLE));
    assign w_maj     = majority3(r_votes[1], r_votes[0], w_rx);

    always_comb begin
        w_state_next   = r_state;
        w_sample_next  = r_sample;
        w_bit_idx_next = r_bit_idx;
        w_votes_next   = r_votes;
        w_shift_next   = r_shift;
        w_restart      = 1'b0;
        w_deliver      = 1'b0;
        w_frame_set    = 1'b0;

        // Count 0 is the bit start; a tick advances to the count it names.
        if (w_tick) begin
            w_sample_next = w_cnt_inc;
            if (w_cnt_inc == 4'(MID_LO)) begin
                w_votes_next[1] = w_rx;
            end
            if (w_cnt_inc == 4'(MID_LO + 1)) begin
                w_votes_next[0] = w_rx;
            end
        end

        unique case (r_state)
            WAIT_HIGH: begin
                // Ignore the synchronizer's reset value until real pin samples arrive.
                if (w_rx && r_primed[1]) begin
                    w_state_next = IDLE;
                end
            end
            IDLE: begin
                if (!w_rx) begin
                    w_state_next  = START;
                    w_sample_next = 4'd0;
                    w_restart     = 1'b1;
                end
            end
            START: begin
                if (w_mid && w_maj) begin
                    w_state_next = IDLE;
                end else if (w_bit_end) begin
                    w_state_next   = DATA;
                    w_bit_idx_next = 3'd0;
                end
            end
            DATA: begin
                if (w_mid) begin
                    w_shift_next = {w_maj, r_shift[7:1]};
                end
                if (w_bit_end) begin
                    if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (w_mid) begin
                    if (w_maj) begin
                        w_deliver    = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_frame_set  = 1'b1;
                        w_state_next = WAIT_HIGH;
                    end
                end
            end
            default: w_state_next = WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_primed    <= 2'b00;
            r_state     <= WAIT_HIGH;
            r_sample    <= 4'd0;
            r_bit_idx   <= 3'd0;
            r_votes     <= 2'b00;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1   <= rx_in;
            r_sync2   <= r_sync1;
            r_primed  <= {r_primed[0], 1'b1};
            r_state   <= w_state_next;
            r_sample  <= w_sample_next;
            r_bit_idx <= w_bit_idx_next;
            r_votes   <= w_votes_next;
            r_shift   <= w_shift_next;

            if (w_deliver && (!r_valid || rx_ack)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (rx_ack) begin
                r_valid <= 1'b0;
            end

            if (w_deliver && r_valid && !rx_ack) begin
                r_overrun <= 1'b1;
            end else if (rx_ack) begin
                r_overrun <= 1'b0;
            end

            // A new framing error outranks a simultaneous ack.
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (rx_ack) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE) && (r_state != WAIT_HIGH);

endmodule
